// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
//
// APB master shared by NREQ internal requesters. Pending requests are
// arbitrated round-robin. The winner is sequenced through the APB SETUP
// and ACCESS phases, and its completion is reported back on done,
// resp_rdata and resp_err.
//
// Timing: a request sampled in IDLE at edge N produces SETUP on the bus
// during cycle N+1 and ACCESS during cycle N+2. With no wait states,
// pready is sampled at edge N+3 and done is high from edge N+3 to N+4.
//
// Optional feature: define APB_ARB_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT samples of pready=0. An aborted transfer completes with
// resp_err=1 and resp_rdata=0.
//
// Ports
//   pclk, prst            clock, synchronous active-low reset
//   req, req_write        per-requester request and direction (1 = write)
//   req_addr, req_wdata   packed per-requester address / write data
//   done                  one-hot, one-cycle completion pulse
//   resp_rdata, resp_err  completion data/error, valid while done != 0
//   psel, penable, pwrite, paddr, pwdata   APB request (all registered)
//   prdata, pready, pslverr                APB response
module apb_master_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               pclk,
  input  logic               prst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      resp_rdata,
  output logic               resp_err,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic [DW-1:0]      prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int LW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("apb_master_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("apb_master_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t          state, state_d;
  logic [LW-1:0]   last, last_d;
  logic [LW-1:0]   winner;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] done_d;
  logic            found;
  int              cand;
  logic            psel_d, penable_d, pwrite_d, resp_err_d;
  logic [AW-1:0]   paddr_d;
  logic [DW-1:0]   pwdata_d, resp_rdata_d;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt, wait_cnt_d;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d      = state;
    last_d       = last;
    psel_d       = psel;
    penable_d    = penable;
    pwrite_d     = pwrite;
    paddr_d      = paddr;
    pwdata_d     = pwdata;
    done_d       = '0;
    resp_rdata_d = resp_rdata;
    resp_err_d   = resp_err;
    // The requester whose done is high right now is still holding req;
    // masking it keeps it from winning again immediately.
    eligible     = req & ~done;
    found        = 1'b0;
    winner       = last;
    cand         = 0;
`ifdef APB_ARB_TIMEOUT_EN
    wait_cnt_d   = wait_cnt;
`endif

    unique case (state)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        // Round-robin search starting just after the last winner.
        for (int i = 1; i <= NREQ; i++) begin
          cand = (int'(last) + i) % NREQ;
          if (!found && eligible[cand[LW-1:0]]) begin
            found  = 1'b1;
            winner = cand[LW-1:0];
          end
        end
        if (found) begin
          pwrite_d = req_write[winner];
          paddr_d  = req_addr[winner*AW +: AW];
          pwdata_d = req_wdata[winner*DW +: DW];
          last_d   = winner;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b0;
        state_d   = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end

      ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        // The bus lags the state register by one cycle, so pready is only
        // meaningful once penable is already high on the bus.
        if (penable) begin
          if (pready) begin
            state_d      = IDLE;
            psel_d       = 1'b0;
            penable_d    = 1'b0;
            done_d[last] = 1'b1;
            resp_rdata_d = pwrite ? '0 : prdata;
            resp_err_d   = pslverr;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (wait_cnt + 1'b1 == CW'(TIMEOUT)) begin
            state_d      = IDLE;
            psel_d       = 1'b0;
            penable_d    = 1'b0;
            done_d[last] = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt + 1'b1;
          end
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!prst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the values from before this edge.
      state      <= IDLE;
      last       <= LW'(NREQ - 1);
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      done       <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      state      <= state_d;
      last       <= last_d;
      psel       <= psel_d;
      penable    <= penable_d;
      pwrite     <= pwrite_d;
      paddr      <= paddr_d;
      pwdata     <= pwdata_d;
      done       <= done_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
`ifdef APB_ARB_TIMEOUT_EN
      wait_cnt   <= wait_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter (NREQ=4, AW=8, DW=8, TIMEOUT=16).
// Reset, fairness and mid-transfer reset are hand-written sequences; single
// transfers come from a table of directed vectors with hand-computed results.
// The timeout vector is only added when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_master_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 8;

  logic               pclk = 1'b0;
  logic               prst;
  logic [NREQ-1:0]    req, req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      resp_rdata;
  logic               resp_err;
  logic               psel, penable, pwrite;
  logic [AW-1:0]      paddr;
  logic [DW-1:0]      pwdata;
  logic [DW-1:0]      prdata;
  logic               pready, pslverr;

  int checks = 0;
  int errors = 0;

  apb_master_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .pclk(pclk), .prst(prst),
    .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         idx;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata_in;
    logic       err_in;
    int         waits;
    logic [3:0] exp_done;
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_access;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Advance until the bus is in SETUP (psel=1, penable=0); checks the
  // current cycle first. Returns the number of edges taken.
  task automatic wait_setup(output int n);
    n = 0;
    while (!(psel === 1'b1 && penable === 1'b0) && n < 30) begin
      tick();
      n++;
    end
    check("setup_reached", 32'(psel === 1'b1 && penable === 1'b0), 1);
  endtask

  task automatic run_vec(input vec_t v);
    int  lat, acc, guard;
    bit  stable;
    req_write[v.idx]           = v.wr;
    req_addr[v.idx*AW +: AW]   = v.addr;
    req_wdata[v.idx*DW +: DW]  = v.wdata;
    prdata                     = v.rdata_in;
    pslverr                    = v.err_in;
    pready                     = 1'b0;
    req                        = 4'(1 << v.idx);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (psel !== 1'b1 && lat < 10);
    check("grant_latency", lat, 2);
    check("setup_penable", penable, 0);
    check("setup_paddr", paddr, v.addr);
    check("setup_pwrite", pwrite, v.wr);
    check("setup_pwdata", pwdata, v.wdata);
    acc = 0; guard = 0; stable = 1;
    while (guard < 40) begin
      tick();
      guard++;
      if (psel !== 1'b1) break;
      if (penable === 1'b1) acc++;
      if (paddr !== v.addr || pwdata !== v.wdata || pwrite !== v.wr) stable = 0;
      pready = (acc > v.waits);
    end
    pready = 1'b0;
    check("access_cycles", acc, v.exp_access);
    check("access_stable", 32'(stable), 1);
    check("done", done, v.exp_done);
    check("resp_rdata", resp_rdata, v.exp_rdata);
    check("resp_err", resp_err, v.exp_err);
    req = '0;
    tick();
    check("done_pulse_end", done, 0);
    check("resp_rdata_hold", resp_rdata, v.exp_rdata);
    tick();
  endtask

  vec_t vecs[$];
  int   order[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    int n;
    //         idx wr  addr   wdata  rdin   err waits done     rdata  err acc
    vecs.push_back('{2, 1'b1, 8'h12, 8'hA5, 8'h00, 1'b0, 0, 4'b0100, 8'h00, 1'b0, 1});
    vecs.push_back('{1, 1'b0, 8'h30, 8'h00, 8'h5C, 1'b0, 3, 4'b0010, 8'h5C, 1'b0, 4});
    vecs.push_back('{3, 1'b1, 8'hFF, 8'h3C, 8'h00, 1'b1, 0, 4'b1000, 8'h00, 1'b1, 1});
    vecs.push_back('{0, 1'b0, 8'h00, 8'h00, 8'h81, 1'b0, 1, 4'b0001, 8'h81, 1'b0, 2});
    vecs.push_back('{3, 1'b0, 8'h7E, 8'h00, 8'hE7, 1'b1, 0, 4'b1000, 8'hE7, 1'b1, 1});
    vecs.push_back('{2, 1'b1, 8'h55, 8'hFF, 8'hAA, 1'b0, 2, 4'b0100, 8'h00, 1'b0, 3});
`ifdef APB_ARB_TIMEOUT_EN
    vecs.push_back('{1, 1'b0, 8'h44, 8'h00, 8'h99, 1'b0, 1000, 4'b0010, 8'h00, 1'b1, 16});
`endif

    // Reset with every requester pending.
    prst = 1'b0;
    req = 4'b1111;
    req_write = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW]  = 8'(8'h40 + i);
      req_wdata[i*DW +: DW] = 8'(8'h10 + i);
    end
    prdata = 8'h90; pready = 1'b1; pslverr = 1'b0;
    tick();
    tick();
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_done", done, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);

    // Release: psel rises at the second edge after release, requester 0 first.
    prst = 1'b1;
    tick();
    check("rel_edge1_psel", psel, 0);
    tick();
    check("rel_edge2_psel", psel, 1);
    check("rel_first_grant", paddr, 8'h40);

    // Fairness: all requesters stay high; grants rotate 0,1,2,3,0,1.
    foreach (order[g]) begin
      wait_setup(n);
      check("fair_grant_addr", paddr, 32'(8'h40 + order[g]));
      n = 0;
      do begin
        tick();
        n++;
      end while (done === '0 && n < 20);
      check("fair_done", done, 32'(1 << order[g]));
      check("fair_rdata", resp_rdata, 8'h90);
    end
    req = '0;
    pready = 1'b0;
    repeat (4) tick();
    check("idle_psel", psel, 0);

    // Reset in the middle of a wait-stated ACCESS: transfer aborts silently.
    req = 4'b0001;
    wait_setup(n);
    tick();
    check("midrst_in_access", 32'(psel && penable), 1);
    prst = 1'b0;
    tick();
    prst = 1'b1;
    req = '0;
    check("midrst_psel", psel, 0);
    check("midrst_penable", penable, 0);
    check("midrst_done", done, 0);
    tick();
    check("midrst_no_done", done, 0);
    tick();

    // Directed single transfers.
    foreach (vecs[k]) run_vec(vecs[k]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
